// File: rtl/lsu_mem_ctrl.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid bus, aligns load data, flags misaligned/faulting accesses.
// Latency: 3 cycles for a load/store with gnt in the request cycle and rvalid the next; stalls ex_mem while a transaction is open.
// Optional macro LSU_BUS_TIMEOUT_EN bounds gnt/rvalid waits to TIMEOUT_CYCLES and turns an expiry into an access fault.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        rd_we_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_wdata_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_err_i,
    output logic        stall_req_o,
    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_wdata_o,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        exc_valid_o,
    output logic [3:0]  exc_cause_o,
    output logic [31:0] exc_tval_o
);

    typedef enum logic [2:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE, ABORT} state_t;

    state_t      state_q, state_d;
    logic [31:0] load_q, load_d;
    logic        err_q, err_d;

    logic is_load, is_store, is_byte, is_half, is_word, is_uns;
    logic is_mem, misaligned, bus_drive, tmo_hit;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        is_uns   = 1'b0;
        case (mem_op_i)
            4'd1: begin is_load  = 1'b1; is_byte = 1'b1; end
            4'd2: begin is_load  = 1'b1; is_half = 1'b1; end
            4'd3: begin is_load  = 1'b1; is_word = 1'b1; end
            4'd4: begin is_load  = 1'b1; is_byte = 1'b1; is_uns = 1'b1; end
            4'd5: begin is_load  = 1'b1; is_half = 1'b1; is_uns = 1'b1; end
            4'd6: begin is_store = 1'b1; is_byte = 1'b1; end
            4'd7: begin is_store = 1'b1; is_half = 1'b1; end
            4'd8: begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = (is_half & mem_addr_i[0]) | (is_word & (|mem_addr_i[1:0]));

    logic [3:0]  be_base;
    logic [31:0] bus_wdata;
    logic [31:0] rdata_shift;
    logic [31:0] load_ext;

    always_comb begin
        be_base   = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);
        bus_wdata = is_byte ? {4{mem_wdata_i[7:0]}} :
                    (is_half ? {2{mem_wdata_i[15:0]}} : mem_wdata_i);
        rdata_shift = dbus_rdata_i >> {mem_addr_i[1:0], 3'b000};
        if (is_byte)
            load_ext = is_uns ? {24'd0, rdata_shift[7:0]}
                              : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
        else if (is_half)
            load_ext = is_uns ? {16'd0, rdata_shift[15:0]}
                              : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
        else
            load_ext = rdata_shift;
    end

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // Counter restarts on every state change, so it measures time spent in the current wait state.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            tmo_cnt <= '0;
        else if (state_d != state_q)
            tmo_cnt <= '0;
        else if (state_q == WAIT_GNT || state_q == WAIT_RSP || state_q == ABORT)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        err_d        = err_q;
        bus_drive    = 1'b0;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = '0;
        dbus_be_o    = '0;
        dbus_wdata_o = '0;
        stall_req_o  = 1'b0;
        rd_we_o      = 1'b0;
        rd_addr_o    = rd_addr_i;
        rd_wdata_o   = rd_wdata_i;
        csr_we_o     = 1'b0;
        csr_waddr_o  = csr_waddr_i;
        csr_wdata_o  = csr_wdata_i;
        exc_valid_o  = 1'b0;
        exc_cause_o  = '0;
        exc_tval_o   = '0;

        case (state_q)
            IDLE: begin
                if (!flush_i) begin
                    if (!is_mem) begin
                        rd_we_o  = rd_we_i;
                        csr_we_o = csr_we_i;
                    end else if (misaligned) begin
                        exc_valid_o = 1'b1;
                        exc_cause_o = is_load ? 4'd4 : 4'd6;
                        exc_tval_o  = mem_addr_i;
                    end else begin
                        bus_drive   = 1'b1;
                        stall_req_o = 1'b1;
                        load_d      = '0;
                        err_d       = 1'b0;
                        state_d     = dbus_gnt_i ? WAIT_RSP : WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    bus_drive   = 1'b1;
                    stall_req_o = 1'b1;
                    // A grant wins over a simultaneous expiry so no response is left orphaned.
                    if (dbus_gnt_i) begin
                        state_d = WAIT_RSP;
                    end else if (tmo_hit) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WAIT_RSP: begin
                stall_req_o = 1'b1;
                if (dbus_rvalid_i) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        load_d  = is_load ? load_ext : 32'd0;
                        err_d   = dbus_err_i;
                        state_d = DONE;
                    end
                end else if (flush_i) begin
                    state_d = ABORT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush_i) begin
                    if (err_q) begin
                        exc_valid_o = 1'b1;
                        exc_cause_o = is_load ? 4'd5 : 4'd7;
                        exc_tval_o  = mem_addr_i;
                    end else begin
                        rd_we_o    = is_load & rd_we_i;
                        rd_wdata_o = is_load ? load_q : rd_wdata_i;
                        csr_we_o   = csr_we_i;
                    end
                end
            end
            ABORT: begin
                stall_req_o = 1'b1;
                if (dbus_rvalid_i || tmo_hit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus_drive) begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = is_store;
            dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
            dbus_be_o    = be_base << mem_addr_i[1:0];
            dbus_wdata_o = is_store ? bus_wdata : 32'd0;
        end

        // Outputs read as zero while reset is held, independent of ex_mem contents.
        if (rst_i) begin
            dbus_req_o   = 1'b0;
            dbus_we_o    = 1'b0;
            dbus_addr_o  = '0;
            dbus_be_o    = '0;
            dbus_wdata_o = '0;
            stall_req_o  = 1'b0;
            rd_we_o      = 1'b0;
            rd_addr_o    = '0;
            rd_wdata_o   = '0;
            csr_we_o     = 1'b0;
            csr_waddr_o  = '0;
            csr_wdata_o  = '0;
            exc_valid_o  = 1'b0;
            exc_cause_o  = '0;
            exc_tval_o   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            load_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: hand-computed vectors for loads, stores, faults, flush and optional timeout.
module tb_lsu_mem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        rd_we_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_wdata_i;
    logic        csr_we_i;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
    logic [31:0] dbus_rdata_i;
    logic        stall_req_o, rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_wdata_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        exc_valid_o;
    logic [3:0]  exc_cause_o;
    logic [31:0] exc_tval_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_wdata_i(rd_wdata_i),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
        .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
        .stall_req_o(stall_req_o),
        .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clr();
        flush_i = 0; mem_op_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        rd_we_i = 0; rd_addr_i = 0; rd_wdata_i = 0;
        csr_we_i = 0; csr_waddr_i = 0; csr_wdata_i = 0;
        dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0; dbus_err_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives op none with a GPR write and confirms it passes straight through (i.e. FSM is in IDLE).
    task automatic expect_idle(input string tag);
        mem_op_i = 0; rd_we_i = 1; rd_addr_i = 5'd9;
        @(negedge clk_i);
        check({tag, ".idle_we"}, rd_we_o, 1);
        check({tag, ".idle_stall"}, stall_req_o, 0);
        step();
        clr();
    endtask

    // gnt in the request cycle, rvalid the next cycle, then DONE.
    task automatic access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                          input logic [3:0] be, input logic [31:0] exp_bus_wd,
                          input logic exp_we, input logic [31:0] exp_res);
        logic st;
        st = (op >= 4'd6);
        mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
        rd_we_i = 1; rd_addr_i = 5'd5; rd_wdata_i = 32'h5555_5555;
        dbus_gnt_i = 1;
        @(negedge clk_i);
        check({tag, ".req"}, dbus_req_o, 1);
        check({tag, ".addr"}, dbus_addr_o, {addr[31:2], 2'b00});
        check({tag, ".be"}, dbus_be_o, be);
        check({tag, ".we"}, dbus_we_o, st);
        check({tag, ".stall1"}, stall_req_o, 1);
        if (st) check({tag, ".wdata"}, dbus_wdata_o, exp_bus_wd);
        step();
        dbus_gnt_i = 0; dbus_rvalid_i = 1; dbus_rdata_i = rdata; dbus_err_i = err;
        @(negedge clk_i);
        check({tag, ".stall2"}, stall_req_o, 1);
        check({tag, ".req2"}, dbus_req_o, 0);
        check({tag, ".rdwe2"}, rd_we_o, 0);
        step();
        dbus_rvalid_i = 0; dbus_err_i = 0; dbus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        check({tag, ".stall3"}, stall_req_o, 0);
        check({tag, ".rd_we"}, rd_we_o, exp_we);
        if (exp_we) begin
            check({tag, ".rd_addr"}, rd_addr_o, 5);
            check({tag, ".result"}, rd_wdata_o, exp_res);
        end
        check({tag, ".exc"}, exc_valid_o, err);
        if (err) begin
            check({tag, ".cause"}, exc_cause_o, st ? 4'd7 : 4'd5);
            check({tag, ".tval"}, exc_tval_o, addr);
        end
        step();
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr();
        rst_i = 1; rd_we_i = 1; rd_addr_i = 5'd3; csr_we_i = 1; mem_op_i = 4'd3;
        dbus_gnt_i = 1;
        @(negedge clk_i);
        check("rst.rd_we", rd_we_o, 0);
        check("rst.csr_we", csr_we_o, 0);
        check("rst.rd_addr", rd_addr_o, 0);
        check("rst.req", dbus_req_o, 0);
        check("rst.stall", stall_req_o, 0);
        check("rst.exc", exc_valid_o, 0);
        step(); step();
        rst_i = 0; clr();

        // Pass-through with a stray rvalid that must be ignored.
        rd_we_i = 1; rd_addr_i = 5'd7; rd_wdata_i = 32'h1234_5678;
        csr_we_i = 1; csr_waddr_i = 12'h305; csr_wdata_i = 32'hCAFE_0001;
        dbus_rvalid_i = 1;
        @(negedge clk_i);
        check("pt.rd_we", rd_we_o, 1);
        check("pt.rd_addr", rd_addr_o, 7);
        check("pt.rd_wdata", rd_wdata_o, 32'h1234_5678);
        check("pt.csr_we", csr_we_o, 1);
        check("pt.csr_waddr", csr_waddr_o, 12'h305);
        check("pt.csr_wdata", csr_wdata_o, 32'hCAFE_0001);
        check("pt.req", dbus_req_o, 0);
        check("pt.stall", stall_req_o, 0);
        step(); clr();
        expect_idle("pt");

        //     tag     op    addr          wdata         rdata         err  be       bus wdata     we  result
        access("lw",   4'd3, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        1, 32'hDEAD_BEEF);
        access("lb",   4'd1, 32'h0000_0103, 32'h0,        32'h8000_0000, 0, 4'b1000, 32'h0,        1, 32'hFFFF_FF80);
        access("lbu",  4'd4, 32'h0000_0103, 32'h0,        32'h8000_0000, 0, 4'b1000, 32'h0,        1, 32'h0000_0080);
        access("lhu",  4'd5, 32'h0000_0102, 32'h0,        32'hABCD_0000, 0, 4'b1100, 32'h0,        1, 32'h0000_ABCD);
        access("lh",   4'd2, 32'h0000_0100, 32'h0,        32'h0000_8001, 0, 4'b0011, 32'h0,        1, 32'hFFFF_8001);
        access("lb1",  4'd1, 32'h0000_0101, 32'h0,        32'h1122_7F44, 0, 4'b0010, 32'h0,        1, 32'h0000_007F);
        access("sh",   4'd7, 32'h0000_0202, 32'h0000_1234, 32'h0,        0, 4'b1100, 32'h1234_1234, 0, 32'h0);
        access("sb",   4'd6, 32'h0000_0201, 32'h0000_00A5, 32'h0,        0, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0);
        access("sw",   4'd8, 32'h0000_0204, 32'h0BAD_F00D, 32'h0,        0, 4'b1111, 32'h0BAD_F00D, 0, 32'h0);
        access("lwerr",4'd3, 32'h0000_0104, 32'h0,        32'h1111_1111, 1, 4'b1111, 32'h0,        0, 32'h0);
        access("swerr",4'd8, 32'h0000_0300, 32'h7777_7777, 32'h0,        1, 4'b1111, 32'h7777_7777, 0, 32'h0);

        // Misaligned accesses fault in the same cycle without touching the bus.
        mem_op_i = 4'd3; mem_addr_i = 32'h0000_0101; rd_we_i = 1; dbus_gnt_i = 1;
        @(negedge clk_i);
        check("mis_lw.req", dbus_req_o, 0);
        check("mis_lw.exc", exc_valid_o, 1);
        check("mis_lw.cause", exc_cause_o, 4);
        check("mis_lw.tval", exc_tval_o, 32'h0000_0101);
        check("mis_lw.stall", stall_req_o, 0);
        check("mis_lw.rd_we", rd_we_o, 0);
        step(); clr();
        mem_op_i = 4'd7; mem_addr_i = 32'h0000_0203;
        @(negedge clk_i);
        check("mis_sh.req", dbus_req_o, 0);
        check("mis_sh.cause", exc_cause_o, 6);
        check("mis_sh.tval", exc_tval_o, 32'h0000_0203);
        step(); clr();
        expect_idle("mis");

        // Flush while waiting for the response: stall held until rvalid, no write-back.
        mem_op_i = 4'd3; mem_addr_i = 32'h0000_0100; rd_we_i = 1; rd_addr_i = 5'd5;
        dbus_gnt_i = 1;
        step();
        dbus_gnt_i = 0; flush_i = 1;
        @(negedge clk_i);
        check("fl.stall_rsp", stall_req_o, 1);
        step();
        clr();
        for (int i = 0; i < 3; i++) begin
            dbus_rvalid_i = (i == 2);
            dbus_rdata_i  = 32'hDEAD_BEEF;
            @(negedge clk_i);
            check($sformatf("fl.stall_abort%0d", i), stall_req_o, 1);
            check($sformatf("fl.rd_we_abort%0d", i), rd_we_o, 0);
            step();
        end
        clr();
        expect_idle("fl");

        // Flush while waiting for the grant drops the request.
        mem_op_i = 4'd3; mem_addr_i = 32'h0000_0400;
        step();
        @(negedge clk_i);
        check("flg.req_hold", dbus_req_o, 1);
        check("flg.addr_hold", dbus_addr_o, 32'h0000_0400);
        flush_i = 1;
        #1;
        check("flg.req_drop", dbus_req_o, 0);
        step(); clr();
        expect_idle("flg");

`ifdef LSU_BUS_TIMEOUT_EN
        // Grant never arrives: four WAIT_GNT cycles, then a store access fault.
        mem_op_i = 4'd8; mem_addr_i = 32'h0000_0500; mem_wdata_i = 32'h1;
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check($sformatf("tmo.req%0d", i), dbus_req_o, 1);
            step();
        end
        @(negedge clk_i);
        check("tmo.exc", exc_valid_o, 1);
        check("tmo.cause", exc_cause_o, 7);
        check("tmo.tval", exc_tval_o, 32'h0000_0500);
        check("tmo.stall", stall_req_o, 0);
        step(); clr();
        expect_idle("tmo");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
